// File: rtl/duty_fader_if.sv
// Target-set handshake and duty/status outputs of the
// four-channel duty fader.
interface duty_fader_if;
  logic       tgt_valid;
  logic       tgt_ready;
  logic [7:0] tgt0;
  logic [7:0] tgt1;
  logic [7:0] tgt2;
  logic [7:0] tgt3;
  logic [7:0] rate;
  logic [3:0] step;
  logic [7:0] duty0;
  logic [7:0] duty1;
  logic [7:0] duty2;
  logic [7:0] duty3;
  logic       busy;
  logic       done;

  modport master (
    output tgt_valid, tgt0, tgt1, tgt2, tgt3, rate, step,
    input  tgt_ready, duty0, duty1, duty2, duty3, busy, done
  );

  modport slave (
    input  tgt_valid, tgt0, tgt1, tgt2, tgt3, rate, step,
    output tgt_ready, duty0, duty1, duty2, duty3, busy, done
  );
endinterface

// File: rtl/duty_fader.sv
// Four-channel (R,G,B,W) duty fader: steps each duty toward
// its latched target on a prescaled tick, then pulses done.
module duty_fader (
  input  logic         clk,
  input  logic         reset,
  input  logic         clk_en,
  duty_fader_if.slave  bus
);

  typedef enum logic {IDLE, FADE} state_e;

  state_e          state_q, state_d;
  logic [3:0][7:0] duty_q, duty_d;
  logic [3:0][7:0] tgt_q, tgt_d;
  logic [7:0]      rate_q, rate_d;
  logic [3:0]      step_q, step_d;
  logic [7:0]      pre_q, pre_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [3:0][7:0] tgt_in;
  logic            accept;
  logic            all_eq;
  logic            tick;

  // Gap compare keeps the result clamped at the target.
  function automatic logic [7:0] fade(
    input logic [7:0] cur,
    input logic [7:0] tgt,
    input logic [3:0] stp
  );
    logic [7:0] gap;
    logic [7:0] inc;
    inc = {4'd0, stp};
    gap = 8'd0;
    fade = cur;
    if (cur < tgt) begin
      gap = tgt - cur;
      fade = (gap <= inc) ? tgt : cur + inc;
    end else begin
      gap = cur - tgt;
      fade = (gap <= inc) ? tgt : cur - inc;
    end
  endfunction

  assign tgt_in = {bus.tgt3, bus.tgt2, bus.tgt1, bus.tgt0};
  assign bus.tgt_ready = (state_q == IDLE);
  assign accept = clk_en & bus.tgt_valid & bus.tgt_ready;
  assign all_eq = (duty_q == tgt_q);
  assign tick = (pre_q == rate_q);

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    rate_d  = rate_q;
    step_d  = step_q;
    pre_d   = pre_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d   = tgt_in;
          rate_d  = bus.rate;
          step_d  = (bus.step == 4'd0) ? 4'd1 : bus.step;
          pre_d   = 8'd0;
          state_d = FADE;
        end
      end
      FADE: begin
        if (all_eq) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (tick) begin
          pre_d = 8'd0;
          for (int i = 0; i < 4; i++) begin
            duty_d[i] = fade(duty_q[i], tgt_q[i], step_q);
          end
        end else begin
          pre_d = pre_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == FADE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      rate_q  <= 8'd0;
      step_q  <= 4'd0;
      pre_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      rate_q  <= rate_d;
      step_q  <= step_d;
      pre_q   <= pre_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.duty0 = duty_q[0];
  assign bus.duty1 = duty_q[1];
  assign bus.duty2 = duty_q[2];
  assign bus.duty3 = duty_q[3];
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_duty_fader.sv
// Directed bench for duty_fader: stimulus pushes hand-computed
// per-cycle expectations, a monitor pops and compares them.
module tb_duty_fader;

  logic clk;
  logic reset;
  logic clk_en;

  duty_fader_if bus ();

  duty_fader dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .bus    (bus.slave)
  );

  typedef struct packed {
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] d3;
    logic       busy;
    logic       done;
    logic       rdy;
  } obs_t;

  typedef struct {
    int   id;
    obs_t v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_n  = 0;
  int   done_cnt = 0;
  logic done_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    obs_t got;
    exp_t e;
    #1;
    got = {bus.duty0, bus.duty1, bus.duty2, bus.duty3,
           bus.busy, bus.done, bus.tgt_ready};
    if (bus.done === 1'b1 && done_prev !== 1'b1) done_cnt++;
    done_prev = bus.done;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL vec%0d got d=%0d,%0d,%0d,%0d b=%b dn=%b r=%b exp d=%0d,%0d,%0d,%0d b=%b dn=%b r=%b",
                 e.id, got.d0, got.d1, got.d2, got.d3,
                 got.busy, got.done, got.rdy,
                 e.v.d0, e.v.d1, e.v.d2, e.v.d3,
                 e.v.busy, e.v.done, e.v.rdy);
      end
    end
  end

  task automatic set_t(input logic [7:0] t0, t1, t2, t3,
                       input logic [7:0] r, input logic [3:0] s);
    bus.tgt0 = t0;
    bus.tgt1 = t1;
    bus.tgt2 = t2;
    bus.tgt3 = t3;
    bus.rate = r;
    bus.step = s;
  endtask

  task automatic cy(input logic en, input logic v,
                    input logic [7:0] e0, e1, e2, e3,
                    input logic b, input logic dn, input logic rd);
    exp_t e;
    clk_en = en;
    bus.tgt_valid = v;
    e.id = vec_n;
    e.v = {e0, e1, e2, e3, b, dn, rd};
    exp_q.push_back(e);
    vec_n++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet(input int n);
    clk_en = 1'b1;
    bus.tgt_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    clk_en = 1'b0;
    bus.tgt_valid = 1'b0;
    set_t(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    // reset applies even with clk_en low
    cy(0, 0, 0, 0, 0, 0, 0, 0, 1);
    reset = 1'b0;
    cy(1, 0, 0, 0, 0, 0, 0, 0, 1);

    // ramp 0 -> 10 with step 3, rate 0
    set_t(10, 0, 0, 0, 0, 3);
    cy(1, 1, 0, 0, 0, 0, 1, 0, 0);
    cy(1, 0, 3, 0, 0, 0, 1, 0, 0);
    cy(1, 0, 6, 0, 0, 0, 1, 0, 0);
    cy(1, 0, 9, 0, 0, 0, 1, 0, 0);
    cy(1, 0, 10, 0, 0, 0, 1, 0, 0);
    cy(1, 0, 10, 0, 0, 0, 0, 1, 1);
    cy(1, 0, 10, 0, 0, 0, 0, 0, 1);

    // bring duty1 up to 200
    set_t(10, 200, 0, 0, 0, 15);
    cy(1, 1, 10, 0, 0, 0, 1, 0, 0);
    quiet(14);
    cy(1, 0, 10, 200, 0, 0, 0, 1, 1);
    cy(1, 0, 10, 200, 0, 0, 0, 0, 1);

    // 200 -> 5, rate 2, step 0 acts as 1
    set_t(10, 5, 0, 0, 2, 0);
    cy(1, 1, 10, 200, 0, 0, 1, 0, 0);
    cy(1, 0, 10, 200, 0, 0, 1, 0, 0);
    cy(1, 0, 10, 200, 0, 0, 1, 0, 0);
    cy(1, 0, 10, 199, 0, 0, 1, 0, 0);
    cy(1, 0, 10, 199, 0, 0, 1, 0, 0);
    cy(1, 0, 10, 199, 0, 0, 1, 0, 0);
    cy(1, 0, 10, 198, 0, 0, 1, 0, 0);
    quiet(577);
    cy(1, 0, 10, 6, 0, 0, 1, 0, 0);
    cy(1, 0, 10, 5, 0, 0, 1, 0, 0);
    cy(1, 0, 10, 5, 0, 0, 0, 1, 1);
    cy(1, 0, 10, 5, 0, 0, 0, 0, 1);

    // upper saturation 250 -> 255 in one tick
    set_t(10, 5, 250, 0, 0, 10);
    cy(1, 1, 10, 5, 0, 0, 1, 0, 0);
    quiet(25);
    cy(1, 0, 10, 5, 250, 0, 0, 1, 1);
    set_t(10, 5, 255, 0, 0, 15);
    cy(1, 1, 10, 5, 250, 0, 1, 0, 0);
    cy(1, 0, 10, 5, 255, 0, 1, 0, 0);
    cy(1, 0, 10, 5, 255, 0, 0, 1, 1);

    // lower saturation 3 -> 0 in one tick
    set_t(10, 5, 3, 0, 0, 12);
    cy(1, 1, 10, 5, 255, 0, 1, 0, 0);
    quiet(21);
    cy(1, 0, 10, 5, 3, 0, 0, 1, 1);
    set_t(10, 5, 0, 0, 0, 15);
    cy(1, 1, 10, 5, 3, 0, 1, 0, 0);
    cy(1, 0, 10, 5, 0, 0, 1, 0, 0);
    cy(1, 0, 10, 5, 0, 0, 0, 1, 1);

    // clk_en toggling: ticks count enabled cycles only
    set_t(10, 5, 0, 4, 1, 2);
    cy(1, 1, 10, 5, 0, 0, 1, 0, 0);
    cy(0, 0, 10, 5, 0, 0, 1, 0, 0);
    cy(1, 0, 10, 5, 0, 0, 1, 0, 0);
    cy(0, 0, 10, 5, 0, 0, 1, 0, 0);
    cy(1, 0, 10, 5, 0, 2, 1, 0, 0);
    cy(0, 0, 10, 5, 0, 2, 1, 0, 0);
    cy(1, 0, 10, 5, 0, 2, 1, 0, 0);
    cy(0, 0, 10, 5, 0, 2, 1, 0, 0);
    cy(1, 0, 10, 5, 0, 4, 1, 0, 0);
    cy(0, 0, 10, 5, 0, 4, 1, 0, 0);
    cy(1, 0, 10, 5, 0, 4, 0, 1, 1);
    cy(0, 0, 10, 5, 0, 4, 0, 1, 1);
    cy(1, 0, 10, 5, 0, 4, 0, 0, 1);

    // tgt_valid held through fade with new targets
    set_t(12, 5, 0, 4, 0, 1);
    cy(1, 1, 10, 5, 0, 4, 1, 0, 0);
    set_t(13, 5, 0, 4, 0, 1);
    cy(1, 1, 11, 5, 0, 4, 1, 0, 0);
    cy(1, 1, 12, 5, 0, 4, 1, 0, 0);
    cy(1, 1, 12, 5, 0, 4, 0, 1, 1);
    cy(0, 1, 12, 5, 0, 4, 0, 1, 1);
    cy(1, 1, 12, 5, 0, 4, 1, 0, 0);
    cy(1, 0, 13, 5, 0, 4, 1, 0, 0);
    cy(1, 0, 13, 5, 0, 4, 0, 1, 1);

    // reset mid-fade abandons without done
    set_t(13, 5, 0, 128, 0, 4);
    cy(1, 1, 13, 5, 0, 4, 1, 0, 0);
    quiet(31);
    cy(1, 0, 13, 5, 0, 128, 0, 1, 1);
    set_t(13, 5, 0, 255, 0, 15);
    cy(1, 1, 13, 5, 0, 128, 1, 0, 0);
    cy(1, 0, 13, 5, 0, 143, 1, 0, 0);
    reset = 1'b1;
    cy(0, 0, 0, 0, 0, 0, 0, 0, 1);
    reset = 1'b0;
    cy(1, 0, 0, 0, 0, 0, 0, 0, 1);

    quiet(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d left exp 0", exp_q.size());
    end
    checks++;
    if (done_cnt != 11) begin
      errors++;
      $display("FAIL done_pulses got %0d exp 11", done_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
